// File: rtl/gerador_pulso_pkg.sv
// Shared definitions for the pulse generators: FSM state encoding and mode constants.
package gerador_pulso_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    ALTO   = 2'b01,
    BAIXO  = 2'b10,
    FIM    = 2'b11
  } estado_t;

  localparam logic MODO_FINITO   = 1'b0;
  localparam logic MODO_CONTINUO = 1'b1;

endpackage

// File: rtl/gerador_trem_pulsos_if.sv
// Request/configuration and status bundle of the pulse-train generator.
interface gerador_trem_pulsos_if #(
  parameter int LARGURA_W = 16,
  parameter int QTDE_W    = 8
) ();

  logic                 gera;
  logic                 para;
  logic                 modo;
  logic [LARGURA_W-1:0] largura;
  logic [LARGURA_W-1:0] intervalo;
  logic [QTDE_W-1:0]    quantidade;
  logic                 pulso;
  logic                 ocupado;
  logic                 pronto;
  logic [QTDE_W-1:0]    contagem;

  modport master (
    output gera, para, modo, largura, intervalo, quantidade,
    input  pulso, ocupado, pronto, contagem
  );

  modport slave (
    input  gera, para, modo, largura, intervalo, quantidade,
    output pulso, ocupado, pronto, contagem
  );

endinterface

// File: rtl/contador_carga.sv
// Loadable down-counter that stops at zero; used as the phase timer.
module contador_carga #(
  parameter int LARGURA = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carrega,
  input  logic [LARGURA-1:0] valor,
  output logic               zero
);

  logic [LARGURA-1:0] r_conta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_conta <= '0;
    end else if (carrega) begin
      r_conta <= valor;
    end else if (r_conta != '0) begin
      r_conta <= r_conta - LARGURA'(1);
    end
  end

  assign zero = (r_conta == '0);

endmodule

// File: rtl/gerador_trem_pulsos.sv
// Run-time configurable pulse-train generator: finite or continuous trains with abort.
module gerador_trem_pulsos
  import gerador_pulso_pkg::*;
#(
  parameter int LARGURA_W = 16,
  parameter int QTDE_W    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  gerador_trem_pulsos_if.slave  bus
);

  estado_t              r_estado;
  logic                 r_pulso;
  logic                 r_ocupado;
  logic                 r_pronto;
  logic [QTDE_W-1:0]    r_contagem;
  logic [LARGURA_W-1:0] r_largura;
  logic [LARGURA_W-1:0] r_intervalo;
  logic [QTDE_W-1:0]    r_qtde;
  logic                 r_modo;

  logic                 w_zero;
  logic                 w_carrega;
  logic [LARGURA_W-1:0] w_valor;
  logic                 w_aceita;
  logic                 w_ultimo;
  logic [LARGURA_W-1:0] w_largura_ini;
  logic [LARGURA_W-1:0] w_intervalo_ini;
  logic [QTDE_W-1:0]    w_qtde_ini;
  logic [QTDE_W-1:0]    w_contagem_inc;

  // Zero lengths and zero count are clamped to 1 when latched.
  assign w_largura_ini   = (bus.largura    == '0) ? LARGURA_W'(1) : bus.largura;
  assign w_intervalo_ini = (bus.intervalo  == '0) ? LARGURA_W'(1) : bus.intervalo;
  assign w_qtde_ini      = (bus.quantidade == '0) ? QTDE_W'(1)    : bus.quantidade;

  assign w_aceita       = (r_estado == OCIOSO) && bus.gera && !bus.para;
  assign w_ultimo       = (r_modo == MODO_FINITO) && ((r_contagem + QTDE_W'(1)) == r_qtde);
  assign w_contagem_inc = ((r_modo == MODO_CONTINUO) && (&r_contagem)) ? r_contagem
                                                                       : r_contagem + QTDE_W'(1);

  // Timer holds (phase length - 1); a phase ends on the edge where it reads zero.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    w_carrega = 1'b0;
    w_valor   = '0;
    unique case (r_estado)
      OCIOSO: if (w_aceita) begin
        w_carrega = 1'b1;
        w_valor   = w_largura_ini - LARGURA_W'(1);
      end
      ALTO: if (!bus.para && w_zero && !w_ultimo) begin
        w_carrega = 1'b1;
        w_valor   = r_intervalo - LARGURA_W'(1);
      end
      BAIXO: if (!bus.para && w_zero) begin
        w_carrega = 1'b1;
        w_valor   = r_largura - LARGURA_W'(1);
      end
      default: ;
    endcase
  end

  contador_carga #(.LARGURA(LARGURA_W)) u_temporizador (
    .clock   (clock),
    .reset   (reset),
    .carrega (w_carrega),
    .valor   (w_valor),
    .zero    (w_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado    <= OCIOSO;
      r_pulso     <= 1'b0;
      r_ocupado   <= 1'b0;
      r_pronto    <= 1'b0;
      r_contagem  <= '0;
      r_largura   <= '0;
      r_intervalo <= '0;
      r_qtde      <= '0;
      r_modo      <= MODO_FINITO;
    end else begin
      r_pronto <= 1'b0;
      if (bus.para && (r_estado == ALTO || r_estado == BAIXO)) begin
        // Abort wins over any phase transition; a truncated pulse is not counted.
        r_estado  <= FIM;
        r_pulso   <= 1'b0;
        r_ocupado <= 1'b0;
        r_pronto  <= 1'b1;
      end else begin
        unique case (r_estado)
          OCIOSO: if (w_aceita) begin
            r_largura   <= w_largura_ini;
            r_intervalo <= w_intervalo_ini;
            r_qtde      <= w_qtde_ini;
            r_modo      <= bus.modo;
            r_contagem  <= '0;
            r_estado    <= ALTO;
            r_pulso     <= 1'b1;
            r_ocupado   <= 1'b1;
          end
          ALTO: if (w_zero) begin
            r_contagem <= w_contagem_inc;
            r_pulso    <= 1'b0;
            if (w_ultimo) begin
              r_estado  <= FIM;
              r_ocupado <= 1'b0;
              r_pronto  <= 1'b1;
            end else begin
              r_estado <= BAIXO;
            end
          end
          BAIXO: if (w_zero) begin
            r_estado <= ALTO;
            r_pulso  <= 1'b1;
          end
          FIM: r_estado <= OCIOSO;
          default: r_estado <= OCIOSO;
        endcase
      end
    end
  end

  assign bus.pulso    = r_pulso;
  assign bus.ocupado  = r_ocupado;
  assign bus.pronto   = r_pronto;
  assign bus.contagem = r_contagem;

endmodule

// File: tb/tb_gerador_trem_pulsos.sv
// Directed bench for gerador_trem_pulsos; outputs sampled on the falling edge.
module tb_gerador_trem_pulsos;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  gerador_trem_pulsos_if #(.LARGURA_W(16), .QTDE_W(8)) bus ();

  gerador_trem_pulsos #(.LARGURA_W(16), .QTDE_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic m, input logic [15:0] l, input logic [15:0] i,
                       input logic [7:0] q);
    bus.modo       = m;
    bus.largura    = l;
    bus.intervalo  = i;
    bus.quantidade = q;
    bus.gera       = 1'b1;
    tick();
    bus.gera       = 1'b0;
  endtask

  logic [17:0] trem_pat;
  logic [6:0]  cont_pat;

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b0;
    bus.gera       = 1'b0;
    bus.para       = 1'b0;
    bus.modo       = 1'b0;
    bus.largura    = '0;
    bus.intervalo  = '0;
    bus.quantidade = '0;

    // Reset state
    tick();
    check("rst_pulso",    bus.pulso,    0);
    check("rst_ocupado",  bus.ocupado,  0);
    check("rst_pronto",   bus.pronto,   0);
    check("rst_contagem", bus.contagem, 0);
    reset = 1'b1;
    tick();

    // Single pulse, L=25, N=1
    start(1'b0, 16'd25, 16'd4, 8'd1);
    check("single_ocupado", bus.ocupado, 1);
    for (int k = 1; k <= 25; k++) begin
      check("single_pulso", bus.pulso, 1);
      check("single_pronto_early", bus.pronto, 0);
      tick();
    end
    check("single_pulso_end",  bus.pulso,    0);
    check("single_pronto",     bus.pronto,   1);
    check("single_ocupado_end", bus.ocupado, 0);
    check("single_contagem",   bus.contagem, 1);
    tick();
    check("single_pronto_once", bus.pronto,  0);
    check("single_hold",        bus.contagem, 1);

    // Train L=3, I=2, N=4: 111 00 111 00 111 00 111, inputs disturbed after latch
    trem_pat = 18'b111001110011100111;
    start(1'b0, 16'd3, 16'd2, 8'd4);
    for (int k = 1; k <= 18; k++) begin
      if (k == 2) begin
        bus.largura    = 16'd7;
        bus.intervalo  = 16'd9;
        bus.quantidade = 8'd1;
      end
      check("train_pulso", bus.pulso, trem_pat[18-k]);
      check("train_pronto_early", bus.pronto, 0);
      if (k == 4) check("train_contagem_mid", bus.contagem, 1);
      tick();
    end
    check("train_pronto",   bus.pronto,   1);
    check("train_pulso_end", bus.pulso,   0);
    check("train_contagem", bus.contagem, 4);
    tick();
    check("train_pronto_once", bus.pronto, 0);
    tick();

    // Zero clamping: one 1-cycle pulse
    start(1'b0, 16'd0, 16'd0, 8'd0);
    check("clamp_pulso", bus.pulso, 1);
    tick();
    check("clamp_pulso_end", bus.pulso,    0);
    check("clamp_pronto",    bus.pronto,   1);
    check("clamp_contagem",  bus.contagem, 1);
    tick();
    tick();

    // Continuous L=2, I=1: 11 0 11 0 1, abort in 3rd pulse, mid-train gera ignored
    cont_pat = 7'b1101101;
    start(1'b1, 16'd2, 16'd1, 8'd1);
    for (int k = 1; k <= 7; k++) begin
      check("cont_pulso", bus.pulso, cont_pat[7-k]);
      if (k == 2) begin
        bus.modo       = 1'b0;
        bus.quantidade = 8'd1;
      end
      if (k == 3) bus.gera = 1'b1;
      if (k == 4) begin
        bus.gera = 1'b0;
        check("cont_contagem_mid", bus.contagem, 1);
      end
      if (k == 7) bus.para = 1'b1;
      tick();
    end
    bus.para = 1'b0;
    check("abort_pulso",    bus.pulso,    0);
    check("abort_pronto",   bus.pronto,   1);
    check("abort_ocupado",  bus.ocupado,  0);
    check("abort_contagem", bus.contagem, 2);
    tick();
    check("abort_pronto_once", bus.pronto, 0);
    check("abort_hold",        bus.contagem, 2);
    tick();

    // Continuous saturation: 300 completed pulses saturate contagem at 255
    start(1'b1, 16'd0, 16'd0, 8'd0);
    repeat (600) tick();
    check("sat_ocupado", bus.ocupado, 1);
    check("sat_contagem_run", bus.contagem, 255);
    bus.para = 1'b1;
    tick();
    bus.para = 1'b0;
    check("sat_pronto",   bus.pronto,   1);
    check("sat_contagem", bus.contagem, 255);
    tick();
    tick();

    // gera and para together in OCIOSO: nothing happens
    bus.largura = 16'd2;
    bus.gera    = 1'b1;
    bus.para    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("both_pulso",    bus.pulso,    0);
      check("both_pronto",   bus.pronto,   0);
      check("both_ocupado",  bus.ocupado,  0);
      check("both_contagem", bus.contagem, 255);
    end
    bus.gera = 1'b0;
    bus.para = 1'b0;
    tick();

    // Asynchronous reset mid-train, then normal restart
    start(1'b0, 16'd10, 16'd1, 8'd1);
    tick();
    tick();
    check("rstmid_pulso_before", bus.pulso, 1);
    #2 reset = 1'b0;
    #1;
    check("rstmid_pulso",    bus.pulso,    0);
    check("rstmid_ocupado",  bus.ocupado,  0);
    check("rstmid_pronto",   bus.pronto,   0);
    check("rstmid_contagem", bus.contagem, 0);
    tick();
    reset = 1'b1;
    tick();
    start(1'b0, 16'd2, 16'd0, 8'd1);
    check("restart_pulso1", bus.pulso, 1);
    tick();
    check("restart_pulso2", bus.pulso, 1);
    tick();
    check("restart_pulso_end", bus.pulso,    0);
    check("restart_pronto",    bus.pronto,   1);
    check("restart_contagem",  bus.contagem, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gerador_trem_pulsos.md
# gerador_trem_pulsos

Parametrised successor of the single-pulse generator: on a `gera` request it emits a train of `quantidade` pulses, each `largura` cycles high separated by `intervalo` cycles low, with all three values supplied at run time instead of fixed by parameter. A continuous mode repeats pulses until `para`. It sits next to the experiment FSMs in the lab datapaths, driving timed strobes (buzzer, LEDs, sensor triggers) and reporting completion through `pronto`.

## Interface
- `LARGURA_W`, 16, width of the `largura` and `intervalo` cycle counts
- `QTDE_W`, 8, width of `quantidade` and `contagem`
- `clock`  in  1  system clock, all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `gera`  in  1  start request, sampled only in state OCIOSO
- `para`  in  1  abort request, sampled in every state
- `modo`  in  1  0 = finite train of `quantidade` pulses, 1 = continuous until `para`
- `largura`  in  LARGURA_W  high time in cycles, latched on accepted `gera`
- `intervalo`  in  LARGURA_W  low time between pulses in cycles, latched on accepted `gera`
- `quantidade`  in  QTDE_W  number of pulses (modo 0), latched on accepted `gera`
- `pulso`  out  1  generated pulse train
- `ocupado`  out  1  high in ALTO and BAIXO
- `pronto`  out  1  one-cycle completion strobe
- `contagem`  out  QTDE_W  pulses whose high phase has completed in the current train

## Operation
- States: OCIOSO, ALTO, BAIXO, FIM.
- Reset (`reset`=0, asynchronous): state OCIOSO, `pulso`=0, `ocupado`=0, `pronto`=0, `contagem`=0, latched registers cleared.
- OCIOSO: `gera`=1 and `para`=0 → latch inputs, clear `contagem`, go to ALTO. `gera`=`para`=1 → stay in OCIOSO.
- Zero clamping at latch time: `largura`=0 and `intervalo`=0 are both treated as 1, and `quantidade`=0 is treated as 1.
- ALTO: `pulso`=1 for exactly L cycles. At the end of the high phase, `contagem` is incremented, with a saturating increment at all-ones in modo 1. Then:
  - modo 0 and last pulse → FIM
  - otherwise → BAIXO
- BAIXO: `pulso`=0 for exactly I cycles, then → ALTO.
- FIM: `pronto`=1 for one cycle, then → OCIOSO. `contagem` holds its final value until the next accepted `gera`.
- `para`=1 in ALTO or BAIXO → FIM on the next edge. `pulso` drops on that edge, which can truncate the current pulse. `contagem` counts only completed high phases.
- `gera` while not in OCIOSO is ignored. Input changes after the latch have no effect on the running train.
- `para` has priority over every internal transition in the same cycle.

## Timing
- `gera` sampled at edge t0 → `pulso` high during cycles t0+1 … t0+L.
- Low gap spans L+1 … L+I after each non-final pulse.
- modo 0, N pulses: `pronto` high for the single cycle starting at t0 + N·L + (N−1)·I + 1. There is no trailing gap after the last pulse.
- `para` sampled at edge tp → `pulso`=0 and `pronto`=1 during cycle tp+1, and `ocupado`=0 from tp+1.
- New `gera` is accepted at the earliest one cycle after `pronto`, once the block is back in OCIOSO.
- All outputs are registered and glitch-free, with no combinational path from inputs to outputs.

## Structure
- Shared package / include `gerador_pulso_pkg`:
  - state encoding localparams (OCIOSO=2'b00, ALTO=2'b01, BAIXO=2'b10, FIM=2'b11)
  - `MODO_FINITO`/`MODO_CONTINUO` constants
- Sub-module `contador_carga` (loadable down-counter, width parameter, `carrega`, `valor`, `zero` outputs), instantiated once for the phase timer.
- The pulse counter is a plain register in the top module.
- Top module: FSM, input latches, `contagem` register.

## Test plan
- Reset mid-train: assert `reset`=0 during ALTO → all outputs 0 immediately, asynchronously. Release → OCIOSO, `gera` accepted normally.
- Single pulse: `largura`=25, `quantidade`=1, `modo`=0, `gera` at t0 → `pulso` high t0+1…t0+25, `pronto` at t0+26, `contagem`=1.
- Train: `largura`=3, `intervalo`=2, `quantidade`=4 → pattern 111 00 111 00 111 00 111, `pronto` at t0+19, `contagem`=4.
- Clamping: `largura`=0, `intervalo`=0, `quantidade`=0 → one 1-cycle pulse, `pronto` at t0+2.
- Continuous plus abort: `modo`=1, `largura`=2, `intervalo`=1, `para` during the 3rd pulse's first high cycle → `pulso` drops next cycle, `pronto` one cycle, `contagem`=2. A `gera` pulsed mid-train is ignored.
- Simultaneous `gera`=`para`=1 in OCIOSO → no pulse, no `pronto`, state remains OCIOSO.
